yutorina_pipeline_core: RTL and testbench

- Parametrised successor to the single-cycle yutorina CPU top.
- Three-stage in-order pipeline: F (fetch), D (decode, register read, branch), E (ALU, writeback).
- Contains its own register file, operand forwarding, branch squash, instruction-memory wait handling, a halt state and a retire counter.
- Connects to the SPM instruction port; a debug port exposes registers to the bench.

---
 rtl/yutorina_pipeline_core.sv | 154 +++++++++++++++
 tb/tb_yutorina_pipeline_core.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yutorina_pipeline_core.sv
// yutorina_pipeline_core: three-stage F/D/E in-order core with
// forwarding, branch squash, imem wait handling and halt.
module yutorina_pipeline_core #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 12,
  parameter int COUNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_address,
  output logic               imem_read_enable,
  input  logic [31:0]        imem_read_data,
  input  logic               imem_ready,
  input  logic [4:0]         debug_read_address,
  output logic [DATA_W-1:0]  debug_read_data,
  output logic               halted,
  output logic [COUNT_W-1:0] retire_count
);
  localparam int SH_W = $clog2(DATA_W);

  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_SHL  = 6'h06;
  localparam logic [5:0] OP_SHR  = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LUI  = 6'h09;
  localparam logic [5:0] OP_BEQ  = 6'h0A;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef struct packed {
    logic              valid;
    logic [5:0]        op;
    logic [4:0]        rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [15:0]       imm;
  } id_ex_t;

  function automatic logic in_rf(input logic [4:0] i);
    return (i != 5'd0) && (int'(i) < REG_COUNT);
  endfunction

  logic [ADDR_W-1:0] pc;
  logic              f_acc;
  logic              halting;
  id_ex_t            e;
  logic [DATA_W-1:0] rf [32];

  // E stage
  logic [DATA_W-1:0] e_sext;
  logic [DATA_W-1:0] alu_y;
  logic              e_writes;
  logic              e_wr;

  assign e_sext = DATA_W'($signed(e.imm));

  always_comb begin
    alu_y    = '0;
    e_writes = 1'b1;
    unique case (1'b1)
      e.op == OP_ADD:  alu_y = e.a + e.b;
      e.op == OP_SUB:  alu_y = e.a - e.b;
      e.op == OP_AND:  alu_y = e.a & e.b;
      e.op == OP_OR:   alu_y = e.a | e.b;
      e.op == OP_XOR:  alu_y = e.a ^ e.b;
      e.op == OP_SHL:  alu_y = e.a << e.b[SH_W-1:0];
      e.op == OP_SHR:  alu_y = e.a >> e.b[SH_W-1:0];
      e.op == OP_ADDI: alu_y = e.a + e_sext;
      e.op == OP_LUI:  alu_y = {{(DATA_W-16){1'b0}}, e.imm} << 16;
      default:         e_writes = 1'b0;
    endcase
  end

  assign e_wr = e.valid && e_writes && in_rf(e.rd);

  // D stage decodes the word returned for last cycle's fetch
  logic [5:0]        d_op;
  logic [4:0]        d_rd;
  logic [4:0]        d_rs;
  logic [4:0]        d_rt;
  logic [15:0]       d_imm;
  logic [DATA_W-1:0] v_rs;
  logic [DATA_W-1:0] v_rt;
  logic [DATA_W-1:0] v_rd;
  logic              d_valid;
  logic              br_take;
  logic              halt_d;
  logic [ADDR_W-1:0] br_off;

  assign {d_op, d_rd, d_rs, d_imm} = imem_read_data;
  assign d_rt = d_imm[15:11];

  assign v_rs = (e_wr && e.rd == d_rs) ? alu_y :
                in_rf(d_rs) ? rf[d_rs] : '0;
  assign v_rt = (e_wr && e.rd == d_rt) ? alu_y :
                in_rf(d_rt) ? rf[d_rt] : '0;
  assign v_rd = (e_wr && e.rd == d_rd) ? alu_y :
                in_rf(d_rd) ? rf[d_rd] : '0;

  assign d_valid = f_acc;
  assign br_take = d_valid && d_op == OP_BEQ && v_rs == v_rd;
  assign halt_d  = d_valid && d_op == OP_HALT;
  assign br_off  = ADDR_W'($signed(d_imm));

  // F stage; pc already points at PC_D + 1 while D is busy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc      <= '0;
      f_acc   <= 1'b0;
      halting <= 1'b0;
    end else if (!halting) begin
      if (halt_d) begin
        halting <= 1'b1;
        f_acc   <= 1'b0;
      end else if (br_take) begin
        pc    <= pc + br_off;
        f_acc <= 1'b0;
      end else begin
        f_acc <= imem_ready;
        if (imem_ready) pc <= pc + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      e <= '0;
    end else begin
      e <= '{valid: d_valid, op: d_op, rd: d_rd,
             a: v_rs, b: v_rt, imm: d_imm};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      halted       <= 1'b0;
      retire_count <= '0;
    end else if (e.valid) begin
      retire_count <= retire_count + 1'b1;
      if (e_wr) rf[e.rd] <= alu_y;
      if (e.op == OP_HALT) halted <= 1'b1;
    end
  end

  assign imem_address     = pc;
  assign imem_read_enable = !halting;
  assign debug_read_data  = in_rf(debug_read_address) ?
                            rf[debug_read_address] : '0;
endmodule

// File: tb/tb_yutorina_pipeline_core.sv
// Bench for yutorina_pipeline_core: directed programs plus random
// programs checked against an instruction-level reference model.
module tb_yutorina_pipeline_core;
  localparam int DW = 64;
  localparam int RC = 16;
  localparam int AW = 4;
  localparam int CW = 32;

  logic          clock;
  logic          reset;
  logic [AW-1:0] imem_address;
  logic          imem_read_enable;
  logic [31:0]   imem_read_data;
  logic          imem_ready;
  logic [4:0]    debug_read_address;
  logic [DW-1:0] debug_read_data;
  logic          halted;
  logic [CW-1:0] retire_count;

  int errors = 0;
  int checks = 0;
  int edges;
  int ref_retired;
  int ref_taken;
  logic [31:0]   mem [16];
  logic [DW-1:0] ref_regs [32];

  yutorina_pipeline_core #(
    .DATA_W(DW), .REG_COUNT(RC), .ADDR_W(AW), .COUNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .imem_address(imem_address),
    .imem_read_enable(imem_read_enable),
    .imem_read_data(imem_read_data),
    .imem_ready(imem_ready),
    .debug_read_address(debug_read_address),
    .debug_read_data(debug_read_data),
    .halted(halted),
    .retire_count(retire_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op,
    input logic [4:0] rd, input logic [4:0] rs, input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] op,
    input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rd, rs, rt, 11'd0};
  endfunction

  function automatic logic [DW-1:0] rget(input logic [4:0] i);
    return (int'(i) < RC) ? ref_regs[i] : '0;
  endfunction

  task automatic rput(input logic [4:0] i, input logic [DW-1:0] v);
    if (i != 0 && int'(i) < RC) ref_regs[i] = v;
  endtask

  // Sequential ISA interpreter: one instruction at a time, no pipeline
  task automatic ref_run();
    logic [5:0]    op;
    logic [4:0]    rd, rs, rt;
    logic [15:0]   imm;
    logic [DW-1:0] a, b, d, sx;
    int pc;
    bit stop;
    pc = 0;
    stop = 0;
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    ref_retired = 0;
    ref_taken = 0;
    for (int s = 0; s < 64 && !stop; s++) begin
      {op, rd, rs, imm} = mem[pc];
      rt = imm[15:11];
      a = rget(rs);
      b = rget(rt);
      d = rget(rd);
      sx = DW'($signed(imm));
      ref_retired++;
      pc = (pc + 1) % 16;
      case (op)
        6'h01: rput(rd, a + b);
        6'h02: rput(rd, a - b);
        6'h03: rput(rd, a & b);
        6'h04: rput(rd, a | b);
        6'h05: rput(rd, a ^ b);
        6'h06: rput(rd, a << b[5:0]);
        6'h07: rput(rd, a >> b[5:0]);
        6'h08: rput(rd, a + sx);
        6'h09: rput(rd, DW'(imm) * 64'd65536);
        6'h0A: if (a == d) begin
          pc = ((pc + int'($signed(imm))) % 16 + 16) % 16;
          ref_taken++;
        end
        6'h3F: stop = 1;
        default: ;
      endcase
    end
  endtask

  task automatic rd_dbg(input int i, output logic [DW-1:0] v);
    debug_read_address = 5'(i);
    #1;
    v = debug_read_data;
  endtask

  // mode 0: always ready, 1: ready low every other cycle, 2: random
  task automatic run_prog(input string tag, input int mode,
                          input int exp_edges, input bit seq_chk,
                          input int rst_at);
    logic [AW-1:0] a_before;
    logic rdy;
    bit done;
    done = 0;
    @(negedge clock);
    reset = 1'b0;
    imem_ready = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    edges = 0;
    while (!done && edges < 200) begin
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = (edges % 2 == 0);
      else rdy = ($urandom_range(0, 2) != 0);
      imem_ready = rdy;
      a_before = imem_address;
      if (seq_chk && edges < 16)
        chk($sformatf("%s addr seq %0d", tag, edges), imem_address, edges);
      @(posedge clock);
      #1;
      imem_read_data = mem[a_before];
      edges++;
      if (mode == 1 && !rdy)
        chk($sformatf("%s addr hold", tag), imem_address, a_before);
      if (edges == rst_at) begin
        chk($sformatf("%s pre-reset addr", tag), imem_address, rst_at);
        reset = 1'b0;
        #1;
        chk($sformatf("%s rst addr", tag), imem_address, 0);
        chk($sformatf("%s rst halted", tag), halted, 0);
        chk($sformatf("%s rst retire", tag), retire_count, 0);
        chk($sformatf("%s rst rden", tag), imem_read_enable, 1);
        return;
      end
      if (halted) done = 1;
      else @(negedge clock);
    end
    chk($sformatf("%s halted", tag), halted, 1);
    if (exp_edges >= 0)
      chk($sformatf("%s cycles", tag), edges, exp_edges);
  endtask

  task automatic check_final(input string tag);
    logic [DW-1:0] v;
    chk($sformatf("%s retire", tag), retire_count, ref_retired);
    chk($sformatf("%s rden", tag), imem_read_enable, 0);
    for (int i = 0; i < 32; i++) begin
      rd_dbg(i, v);
      chk($sformatf("%s r%0d", tag, i), v, ref_regs[i]);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = '0;
  endtask

  task automatic load_fwd();
    clear_mem();
    mem[0] = enc(6'h08, 5'd1, 5'd0, 16'd5);
    mem[1] = enc(6'h08, 5'd2, 5'd1, 16'd3);
    mem[2] = enc_r(6'h01, 5'd3, 5'd2, 5'd1);
    mem[3] = enc(6'h3F, 5'd0, 5'd0, 16'd0);
  endtask

  task automatic load_branch();
    clear_mem();
    mem[0] = enc(6'h08, 5'd1, 5'd0, 16'd1);
    mem[1] = enc(6'h0A, 5'd1, 5'd1, 16'd2);
    mem[2] = enc(6'h08, 5'd4, 5'd0, 16'd9);
    mem[3] = enc(6'h08, 5'd5, 5'd0, 16'd9);
    mem[4] = enc(6'h08, 5'd6, 5'd0, 16'd7);
    mem[5] = enc(6'h3F, 5'd0, 5'd0, 16'd0);
  endtask

  task automatic gen_random();
    logic [5:0]  op;
    logic [4:0]  rd, rs;
    logic [15:0] imm;
    int k;
    for (int i = 0; i < 15; i++) begin
      k = int'($urandom_range(0, 11));
      op = (k <= 9) ? 6'(k) : (k == 10) ? 6'h0A : 6'h15;
      rd = 5'($urandom_range(0, 19));
      rs = 5'($urandom_range(0, 19));
      imm = 16'($urandom);
      if (op == 6'h0A) begin
        imm = 16'($urandom_range(0, 14 - i));
        if ($urandom_range(0, 1) == 1) rs = rd;
      end
      mem[i] = enc(op, rd, rs, imm);
    end
    mem[15] = enc(6'h3F, 5'd0, 5'd0, 16'd0);
  endtask

  initial begin
    logic [DW-1:0] v;
    reset = 1'b0;
    imem_ready = 1'b1;
    imem_read_data = '0;
    debug_read_address = '0;
    clear_mem();
    #2;
    chk("reset addr", imem_address, 0);
    chk("reset rden", imem_read_enable, 1);
    chk("reset halted", halted, 0);
    chk("reset retire", retire_count, 0);
    rd_dbg(1, v);
    chk("reset r1", v, 0);

    load_fwd();
    ref_run();
    run_prog("fwd", 0, 6, 0, -1);
    check_final("fwd");
    rd_dbg(3, v);
    chk("fwd r3 const", v, 13);
    chk("fwd retire const", retire_count, 4);

    load_branch();
    ref_run();
    run_prog("branch", 0, 7, 0, -1);
    check_final("branch");
    rd_dbg(4, v);
    chk("branch r4 const", v, 0);
    rd_dbg(6, v);
    chk("branch r6 const", v, 7);

    load_fwd();
    ref_run();
    run_prog("wait", 1, -1, 0, -1);
    check_final("wait");

    clear_mem();
    mem[0] = enc(6'h09, 5'd1, 5'd0, 16'h8000);
    mem[1] = enc(6'h08, 5'd3, 5'd0, 16'd16);
    mem[2] = enc_r(6'h06, 5'd2, 5'd1, 5'd3);
    mem[3] = enc(6'h08, 5'd7, 5'd0, 16'hFFFF);
    mem[4] = enc(6'h08, 5'd0, 5'd0, 16'd5);
    mem[5] = enc(6'h08, 5'd20, 5'd0, 16'd5);
    mem[6] = enc(6'h3F, 5'd0, 5'd0, 16'd0);
    ref_run();
    run_prog("width", 0, 9, 0, -1);
    check_final("width");
    rd_dbg(1, v);
    chk("width r1 const", v, 64'h0000_0000_8000_0000);
    rd_dbg(2, v);
    chk("width r2 const", v, 64'h0000_8000_0000_0000);
    rd_dbg(7, v);
    chk("width r7 const", v, '1);

    clear_mem();
    mem[15] = enc(6'h3F, 5'd0, 5'd0, 16'd0);
    ref_run();
    run_prog("wrap", 0, 18, 1, -1);
    check_final("wrap");
    chk("wrap retire const", retire_count, 16);

    load_branch();
    run_prog("midrst", 0, -1, 0, 2);
    rd_dbg(1, v);
    chk("midrst r1", v, 0);
    ref_run();
    run_prog("rerun", 0, 7, 0, -1);
    check_final("rerun");

    for (int it = 0; it < 24; it++) begin
      gen_random();
      ref_run();
      if (it % 2 == 0)
        run_prog($sformatf("rnd%0d", it), 0,
                 ref_retired + ref_taken + 2, 0, -1);
      else
        run_prog($sformatf("rnd%0d", it), 2, -1, 0, -1);
      check_final($sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
